vga_timing_receiver: RTL and testbench
======================================

Name: vga_timing_receiver

Overview:
- Sink-side counterpart of the 640x480@60 VGA sync generator.
- Consumes hsync/vsync (active-low) and display-enable. Recovers pixel coordinates, verifies the timing against the nominal raster and reports lock and errors.
- Used as an on-chip monitor on the game's VGA output.
- Also used as the front end of any block that needs pixel coordinates regenerated from the sync stream, such as a frame capture/overlay path.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_TOTAL, 800, clocks per line
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive error-free frames required to assert locked (range 1..15)

Ports:
- vga_clk in 1 pixel clock
- rst in 1 synchronous reset, active high
- hsync_in in 1 horizontal sync, active low
- vsync_in in 1 vertical sync, active low
- de_in in 1 display enable, active high
- pixel_x out 10 recovered column 0..H_TOTAL-1
- pixel_y out 10 recovered row 0..V_TOTAL-1
- pixel_valid out 1 registered de for current coordinates, gated by locked
- frame_start out 1 one-cycle pulse when locked and (pixel_x,pixel_y)=(0,0)
- locked out 1 timing locked
- err_pulse out 1 one-cycle pulse per detected error
- err_type out 2 cause of last error: 0=h, 1=v, 2=de; holds until the next error
- err_count out 16 saturating error count

Behaviour:
- Interface: reset rst, synchronous, active-high; clock vga_clk.
- Reset:
  - All outputs 0; state HUNT; clean-frame counter 0.
  - Reset mid-operation drops locked in the cycle after rst is sampled.
- Input pipeline:
  - Inputs are registered into s1, then s2.
  - hs_start = !hs_s1 & hs_s2; hs_end = hs_s1 & !hs_s2; vs_start likewise on vsync.
- Latency: pixel_x/pixel_y/pixel_valid at cycle t+2 describe the inputs at cycle t (fixed 2 cycles).
- Counters:
  - Default: pixel_x <= (pixel_x==H_TOTAL-1) ? 0 : pixel_x+1.
  - On x wrap: pixel_y <= (pixel_y==V_TOTAL-1) ? 0 : pixel_y+1.
  - On hs_start: pixel_x <= H_VISIBLE+H_FRONT.
  - On vs_start: pixel_x <= 0 and pixel_y <= V_VISIBLE+V_FRONT.
  - Forced loads override the increment.
- Checks are active in H_ALIGNED and above; the de check only in V_ALIGNED and LOCKED:
  - h error: hs_start while the predicted next x != H_VISIBLE+H_FRONT, or hs_end while the predicted next x != H_VISIBLE+H_FRONT+H_SYNC.
  - v error (V_ALIGNED/LOCKED only): vs_start while the predicted next (x,y) != (0, V_VISIBLE+V_FRONT), or vsync deassert while the predicted next y != V_VISIBLE+V_FRONT+V_SYNC.
  - de error: de_s1 != (next_x<H_VISIBLE && next_y<V_VISIBLE).
- Error reporting:
  - Simultaneous errors give a single err_pulse and a single count increment; err_type priority is h > v > de.
  - err_count saturates at 0xFFFF.
- FSM:
  - HUNT: pixel_x/pixel_y held 0. On hs_start: load x and go to H_ALIGNED.
  - H_ALIGNED: x tracks the raster, pixel_y held 0. On vs_start: go to V_ALIGNED with clean counter 0. On h error: go to HUNT.
  - V_ALIGNED: at each vs_start, if no error occurred since the previous vs_start, increment the clean counter, otherwise clear it. Go to LOCKED when the counter reaches LOCK_FRAMES.
  - LOCKED: locked=1.
  - Any error in H_ALIGNED, V_ALIGNED or LOCKED: go to HUNT and clear the clean counter. locked falls in the cycle after the error is detected. The edge that caused the error is not reused for alignment.
- Gating: pixel_valid and frame_start are 0 unless locked.

Decomposition:
- Shared package vga_timing_pkg holds the H_*/V_* constants (shared with the generator) and the FSM state enum.
- One natural sub-module: vga_sync_edge, which holds the 2-stage input register and the start/end edge detect for one sync line, instantiated twice.

Test Plan:
- Reset, then a nominal generator stream → locked rises 2 cycles after the 3rd vs_start; err_count=0 over 5 frames.
- While locked, compare against the generator's counters delayed 2 cycles: exact pixel_x/pixel_y match every cycle. frame_start fires once per 420000 clocks; pixel_valid count per frame = 307200.
- Stretch one line to 801 clocks → err_pulse=1, err_type=0, err_count=1, locked drops. Relock after 3 further vs_starts.
- Force de_in low at generator (100,100) → err_type=2, err_count=1, locked drops.
- Delay vsync by one line (assert at v=491) → err_type=1, err_count=1, locked drops.
- Assert rst for 1 cycle mid-frame while locked → all outputs 0 next cycle; relock follows the normal sequence.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Raster constants for 640x480@60, shared with the sync generator, and the
// receiver's alignment state encoding.
package vga_timing_pkg;

    localparam int H_VISIBLE   = 640;
    localparam int H_FRONT     = 16;
    localparam int H_SYNC      = 96;
    localparam int H_TOTAL     = 800;
    localparam int V_VISIBLE   = 480;
    localparam int V_FRONT     = 10;
    localparam int V_SYNC      = 2;
    localparam int V_TOTAL     = 525;
    localparam int LOCK_FRAMES = 2;

    typedef enum logic [1:0] {
        ST_HUNT      = 2'd0,
        ST_H_ALIGNED = 2'd1,
        ST_V_ALIGNED = 2'd2,
        ST_LOCKED    = 2'd3
    } rx_state_e;

    localparam logic [1:0] ERR_H  = 2'd0;
    localparam logic [1:0] ERR_V  = 2'd1;
    localparam logic [1:0] ERR_DE = 2'd2;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-stage register for one active-low sync line, with assert/deassert
// edge detection between the two stages.
module vga_sync_edge (
    input  logic vga_clk,
    input  logic rst,
    input  logic i_sync_n,
    output logic o_start,
    output logic o_end
);

    logic r_s1;
    logic r_s2;

    // Both stages reset to the idle (deasserted) level.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_sync_n;
            r_s2 <= r_s1;
        end
    end

    assign o_start = !r_s1 && r_s2;
    assign o_end   = r_s1 && !r_s2;

endmodule

// File: rtl/vga_timing_receiver.sv
// Recovers pixel coordinates from an hsync/vsync/de stream, checks them
// against the nominal raster and reports lock and timing errors.
module vga_timing_receiver #(
    parameter int H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
    parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
    parameter int V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
    parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
    parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        de_in,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err_pulse,
    output logic [1:0]  err_type,
    output logic [15:0] err_count
);

    import vga_timing_pkg::rx_state_e;
    import vga_timing_pkg::ST_HUNT;
    import vga_timing_pkg::ST_H_ALIGNED;
    import vga_timing_pkg::ST_V_ALIGNED;
    import vga_timing_pkg::ST_LOCKED;
    import vga_timing_pkg::ERR_H;
    import vga_timing_pkg::ERR_V;
    import vga_timing_pkg::ERR_DE;

    localparam logic [9:0] X_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_X    = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HE_X    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_Y    = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VE_Y    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] X_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] Y_VIS   = 10'(V_VISIBLE);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_FRAMES);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic       w_hs_start;
    logic       w_hs_end;
    logic       w_vs_start;
    logic       w_vs_end;
    logic       r_de_s1;

    rx_state_e  r_state;
    rx_state_e  w_state_nxt;
    logic [3:0] r_clean;
    logic [3:0] w_clean_nxt;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic [9:0] w_x_inc;
    logic [9:0] w_y_inc;
    logic [9:0] w_x_nxt;
    logic [9:0] w_y_nxt;

    logic       w_chk_h;
    logic       w_chk_v;
    logic       w_h_err;
    logic       w_v_err;
    logic       w_de_err;
    logic       w_err;
    logic [1:0] w_err_type;

    logic       r_pixel_valid;
    logic       r_frame_start;
    logic       r_err_pulse;
    logic [1:0] r_err_type;
    logic [15:0] r_err_count;

    vga_sync_edge u_hs_edge (
        .vga_clk  (vga_clk),
        .rst      (rst),
        .i_sync_n (hsync_in),
        .o_start  (w_hs_start),
        .o_end    (w_hs_end)
    );

    vga_sync_edge u_vs_edge (
        .vga_clk  (vga_clk),
        .rst      (rst),
        .i_sync_n (vsync_in),
        .o_start  (w_vs_start),
        .o_end    (w_vs_end)
    );

    always_ff @(posedge vga_clk) begin
        if (rst) r_de_s1 <= 1'b0;
        else     r_de_s1 <= de_in;
    end

    // Free-running prediction; all checks compare the sync stream against it.
    assign w_x_inc = (r_x == X_LAST) ? '0 : r_x + 10'd1;
    assign w_y_inc = (r_x != X_LAST) ? r_y :
                     (r_y == Y_LAST) ? '0 : r_y + 10'd1;

    assign w_chk_h  = (r_state != ST_HUNT);
    assign w_chk_v  = (r_state == ST_V_ALIGNED) || (r_state == ST_LOCKED);
    assign w_h_err  = w_chk_h && ((w_hs_start && (w_x_inc != HS_X)) ||
                                  (w_hs_end   && (w_x_inc != HE_X)));
    assign w_v_err  = w_chk_v && ((w_vs_start && ((w_x_inc != '0) || (w_y_inc != VS_Y))) ||
                                  (w_vs_end   && (w_y_inc != VE_Y)));
    assign w_de_err = w_chk_v && (r_de_s1 != ((w_x_inc < X_VIS) && (w_y_inc < Y_VIS)));
    assign w_err    = w_h_err || w_v_err || w_de_err;
    assign w_err_type = w_h_err ? ERR_H : (w_v_err ? ERR_V : ERR_DE);

    always_comb begin
        w_state_nxt = r_state;
        w_clean_nxt = r_clean;
        w_x_nxt     = w_x_inc;
        w_y_nxt     = w_y_inc;
        if (w_hs_start) w_x_nxt = HS_X;
        if (w_vs_start) begin
            w_x_nxt = '0;
            w_y_nxt = VS_Y;
        end
        case (r_state)
            ST_HUNT: begin
                w_x_nxt = w_hs_start ? HS_X : '0;
                w_y_nxt = '0;
                if (w_hs_start) w_state_nxt = ST_H_ALIGNED;
            end
            ST_H_ALIGNED: begin
                if (w_vs_start) begin
                    w_state_nxt = ST_V_ALIGNED;
                    w_clean_nxt = '0;
                end else begin
                    w_y_nxt = '0;
                end
            end
            ST_V_ALIGNED: begin
                // Any error leaves this state, so reaching a vs_start here means a clean frame.
                if (w_vs_start) begin
                    w_clean_nxt = r_clean + 4'd1;
                    if (r_clean + 4'd1 >= LOCK_N) w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
            end
            default: w_state_nxt = ST_HUNT;
        endcase
        if (w_err) begin
            w_state_nxt = ST_HUNT;
            w_clean_nxt = '0;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            r_state       <= ST_HUNT;
            r_clean       <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_err_pulse   <= 1'b0;
            r_err_type    <= '0;
            r_err_count   <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_clean       <= w_clean_nxt;
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_pixel_valid <= r_de_s1 && (w_state_nxt == ST_LOCKED);
            r_frame_start <= (w_state_nxt == ST_LOCKED) && (w_x_nxt == '0) && (w_y_nxt == '0);
            r_err_pulse   <= w_err;
            if (w_err) begin
                r_err_type  <= w_err_type;
                r_err_count <= sat_inc16(r_err_count);
            end
        end
    end

    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign pixel_valid = r_pixel_valid;
    assign frame_start = r_frame_start;
    assign locked      = (r_state == ST_LOCKED);
    assign err_pulse   = r_err_pulse;
    assign err_type    = r_err_type;
    assign err_count   = r_err_count;

endmodule

// File: tb/tb_vga_timing_receiver.sv
// Directed bench for vga_timing_receiver on a reduced raster (26x16 clocks per
// frame) driven by a behavioural sync generator with fault knobs.
module tb_vga_timing_receiver;

    localparam int HV = 16, HF = 2, HS = 4, HT = 26;
    localparam int VV = 10, VF = 2, VS = 2, VT = 16;
    localparam int FRAME = HT * VT;

    logic        vga_clk  = 1'b0;
    logic        rst      = 1'b1;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        de_in    = 1'b0;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        pixel_valid;
    logic        frame_start;
    logic        locked;
    logic        err_pulse;
    logic [1:0]  err_type;
    logic [15:0] err_count;

    int checks   = 0;
    int failures = 0;

    // generator state and fault knobs
    int gx = 0, gy = 0;
    int stretch_y = -1;
    bit kill_de = 1'b0;
    int kill_x = 0, kill_y = 0;
    bit vs_late = 1'b0;

    // history of driven generator positions (index 1 = two cycles back)
    int hx[2], hy[2], hde[2];

    bit cmp_en = 1'b0;
    bit prev_locked = 1'b0;
    int cyc = 0;
    int n_fs, n_pv, n_ep, vs_cnt, lock_cyc, last_fs;
    int vs_at[8];

    vga_timing_receiver #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_TOTAL(VT),
        .LOCK_FRAMES(2)
    ) dut (
        .vga_clk     (vga_clk),
        .rst         (rst),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .de_in       (de_in),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_type    (err_type),
        .err_count   (err_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic mark();
        n_fs = 0; n_pv = 0; n_ep = 0; vs_cnt = 0;
        lock_cyc = -1; last_fs = -1;
        for (int i = 0; i < 8; i++) vs_at[i] = -100;
    endtask

    task automatic drive_gen();
        logic hs_n, vs_n, de;
        int   vlo;
        vlo  = vs_late ? VV + VF + 1 : VV + VF;
        hs_n = !(gx >= HV + HF && gx < HV + HF + HS);
        vs_n = !(gy >= vlo && gy < vlo + VS);
        de   = (gx < HV) && (gy < VV);
        if (kill_de && gx == kill_x && gy == kill_y) begin
            de      = 1'b0;
            kill_de = 1'b0;
        end
        if (vsync_in && !vs_n) begin
            if (vs_cnt < 8) vs_at[vs_cnt] = cyc;
            vs_cnt++;
        end
        hsync_in = hs_n;
        vsync_in = vs_n;
        de_in    = de;
        hx[0] = gx; hy[0] = gy; hde[0] = int'(de);
        if (gx == ((gy == stretch_y) ? HT : HT - 1)) begin
            gx = 0;
            if (gy == stretch_y) stretch_y = -1;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic tick();
        @(negedge vga_clk);
        cyc++;
        if (frame_start === 1'b1) n_fs++;
        if (pixel_valid === 1'b1) n_pv++;
        if (err_pulse === 1'b1) n_ep++;
        if (locked === 1'b1 && !prev_locked) lock_cyc = cyc;
        prev_locked = (locked === 1'b1);
        if (cmp_en && locked === 1'b1) begin
            check("px", 32'(pixel_x), hx[1]);
            check("py", 32'(pixel_y), hy[1]);
            check("pv", 32'(pixel_valid), hde[1]);
            check("fs", 32'(frame_start), 32'(hx[1] == 0 && hy[1] == 0));
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) check("fs_period", cyc - last_fs, FRAME);
                last_fs = cyc;
            end
        end
        hx[1] = hx[0]; hy[1] = hy[0]; hde[1] = hde[0];
        drive_gen();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_pos(input int x, input int y);
        for (int i = 0; i < 2 * FRAME && !(gx == x && gy == y); i++) tick();
    endtask

    task automatic run_until_err();
        for (int i = 0; i < 2 * FRAME && n_ep == 0; i++) tick();
    endtask

    task automatic reset_checks();
        check("rst_px",  32'(pixel_x), 0);
        check("rst_py",  32'(pixel_y), 0);
        check("rst_pv",  32'(pixel_valid), 0);
        check("rst_fs",  32'(frame_start), 0);
        check("rst_lock", 32'(locked), 0);
        check("rst_ep",  32'(err_pulse), 0);
        check("rst_et",  32'(err_type), 0);
        check("rst_ec",  32'(err_count), 0);
    endtask

    task automatic err_checks(input int exp_type);
        check("ep_seen",     n_ep, 1);
        check("err_pulse",   32'(err_pulse), 1);
        check("err_type",    32'(err_type), exp_type);
        check("err_count",   32'(err_count), 1);
        check("locked_drop", 32'(locked), 0);
    endtask

    task automatic relock_checks(input string tag, input int exp_cnt);
        check({tag, "_delay"}, lock_cyc - vs_at[2], 2);
        check({tag, "_locked"}, 32'(locked), 1);
        check({tag, "_errcnt"}, 32'(err_count), exp_cnt);
    endtask

    initial begin
        hx = '{0, 0}; hy = '{0, 0}; hde = '{0, 0};
        mark();

        // reset state
        run(4);
        reset_checks();
        rst = 1'b0;

        // nominal stream: lock on third vs_start, then compare every cycle
        mark();
        cmp_en = 1'b1;
        run(5 * FRAME);
        relock_checks("lock1", 0);
        check("nominal_no_err", n_ep, 0);

        mark();
        run(2 * FRAME);
        check("fs_count", n_fs, 2);
        check("pv_count", n_pv, 2 * HV * VV);

        // one line stretched by a clock, in vertical blanking
        cmp_en = 1'b0;
        mark();
        stretch_y = VV + VF + VS;
        run_until_err();
        err_checks(0);
        mark();
        cmp_en = 1'b1;
        run(4 * FRAME);
        relock_checks("relock_h", 1);

        // one-cycle reset mid-frame while locked
        wait_pos(5, 3);
        check("pre_rst_locked", 32'(locked), 1);
        cmp_en = 1'b0;
        rst = 1'b1;
        tick();
        reset_checks();
        rst = 1'b0;
        mark();
        cmp_en = 1'b1;
        run(4 * FRAME);
        relock_checks("relock_rst", 0);

        // de dropped at one visible pixel
        cmp_en = 1'b0;
        kill_x = 5; kill_y = 5; kill_de = 1'b1;
        mark();
        run_until_err();
        err_checks(2);

        // clear count and relock, then delay vsync by one line
        wait_pos(5, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mark();
        cmp_en = 1'b1;
        run(4 * FRAME);
        relock_checks("relock_de", 0);
        cmp_en = 1'b0;
        wait_pos(0, 0);
        vs_late = 1'b1;
        mark();
        run_until_err();
        err_checks(1);
        vs_late = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
